// File: rtl/sorted_writeback.sv
// Register file owned by the sorter's writeback stage: bursts a latched sorted vector into
// consecutive (wrapping) entries, with a side write port and a combinational read port.
module sorted_writeback #(
   parameter int unsigned NREGS = 6,
   parameter int unsigned DW    = 4,
   parameter int unsigned AW    = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [NREGS*DW-1:0] in_data,
   input  logic [AW-1:0]       in_count,
   input  logic [AW-1:0]       in_base,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [DW-1:0]       wr_data,
   input  logic [AW-1:0]       rd_addr,
   output logic [DW-1:0]       rd_data,
   output logic [NREGS*DW-1:0] regs_flat,
   output logic                busy,
   output logic                done,
   output logic                cmd_err,
   output logic                wr_drop
);

   typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

   state_t              state;
   logic [DW-1:0]       regs [NREGS];
   logic [NREGS*DW-1:0] data_q;
   logic [AW-1:0]       count_q;
   logic [AW-1:0]       base_q;
   logic [AW-1:0]       k;

   logic                cmd_ok;
   logic                ext_ok;
   logic                last;
   logic [AW:0]         sum;
   logic [AW:0]         widx;
   logic [DW-1:0]       elem;

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);
   assign done     = (state == DONE);

   assign cmd_ok = (in_count <= AW'(NREGS)) && (in_base < AW'(NREGS));
   assign ext_ok = wr_en && (state == IDLE) && (wr_addr < AW'(NREGS));
   assign last   = (k == count_q - AW'(1));

   // Destination wraps modulo NREGS; computed one bit wider so base+k cannot overflow.
   always_comb begin
      sum  = {1'b0, base_q} + {1'b0, k};
      widx = (sum >= (AW+1)'(NREGS)) ? sum - (AW+1)'(NREGS) : sum;
      elem = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (k == AW'(i)) elem = data_q[i*DW +: DW];
      end
   end

   always_comb begin
      rd_data   = '0;
      regs_flat = '0;
      for (int i = 0; i < NREGS; i++) begin
         regs_flat[i*DW +: DW] = regs[i];
         if (rd_addr == AW'(i)) rd_data = regs[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         data_q  <= '0;
         count_q <= '0;
         base_q  <= '0;
         k       <= '0;
         cmd_err <= 1'b0;
         wr_drop <= 1'b0;
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         cmd_err <= 1'b0;
         wr_drop <= wr_en && !ext_ok;
         if (ext_ok) begin
            for (int i = 0; i < NREGS; i++) begin
               if (wr_addr == AW'(i)) regs[i] <= wr_data;
            end
         end
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (cmd_ok) begin
                     data_q  <= in_data;
                     count_q <= in_count;
                     base_q  <= in_base;
                     k       <= '0;
                     state   <= (in_count == '0) ? DONE : WRITE;
                  end else begin
                     cmd_err <= 1'b1;
                  end
               end
            end
            WRITE: begin
               for (int i = 0; i < NREGS; i++) begin
                  if (widx == (AW+1)'(i)) regs[i] <= elem;
               end
               k <= k + AW'(1);
               if (last) state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sorted_writeback.sv
// Directed bench for sorted_writeback: bursts, wrap, illegal commands, port collisions, reset.
module tb_sorted_writeback;

   localparam int NREGS = 6;
   localparam int DW    = 4;
   localparam int AW    = 3;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                in_valid;
   logic                in_ready;
   logic [NREGS*DW-1:0] in_data;
   logic [AW-1:0]       in_count;
   logic [AW-1:0]       in_base;
   logic                wr_en;
   logic [AW-1:0]       wr_addr;
   logic [DW-1:0]       wr_data;
   logic [AW-1:0]       rd_addr;
   logic [DW-1:0]       rd_data;
   logic [NREGS*DW-1:0] regs_flat;
   logic                busy;
   logic                done;
   logic                cmd_err;
   logic                wr_drop;

   int checks   = 0;
   int failures = 0;

   sorted_writeback #(.NREGS(NREGS), .DW(DW), .AW(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_count  (in_count),
      .in_base   (in_base),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .regs_flat (regs_flat),
      .busy      (busy),
      .done      (done),
      .cmd_err   (cmd_err),
      .wr_drop   (wr_drop)
   );

   always #5 clk = ~clk;

   // Advance past the next rising edge; inputs change and outputs are sampled here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ext_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b0; in_data = '0; in_count = '0; in_base = '0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < NREGS; i++) begin
         rd_addr = AW'(i);
         #1;
         checks++;
         if (rd_data !== 4'h0) begin
            failures++;
            $display("FAIL reset_rd[%0d] got=%h want=0", i, rd_data);
         end
      end
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || cmd_err !== 1'b0 ||
          wr_drop !== 1'b0) begin
         failures++;
         $display("FAIL reset_ctrl got rdy=%b busy=%b done=%b err=%b drop=%b want 1 0 0 0 0",
                  in_ready, busy, done, cmd_err, wr_drop);
      end
   endtask

   task automatic test_burst();
      ext_write(3'd0, 4'hC);
      ext_write(3'd1, 4'hD);
      ext_write(3'd2, 4'h8);
      ext_write(3'd3, 4'h9);
      ext_write(3'd4, 4'hB);
      ext_write(3'd5, 4'hE);
      checks++;
      if (regs_flat !== {4'hE, 4'hB, 4'h9, 4'h8, 4'hD, 4'hC} || wr_drop !== 1'b0) begin
         failures++;
         $display("FAIL ext_preload got=%h drop=%b want=eb98dc drop=0", regs_flat, wr_drop);
      end
      in_data = {4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
      in_count = 3'd4; in_base = 3'd1; in_valid = 1'b1;
      tick();  // E0
      in_valid = 1'b0;
      in_data = '1;  // must not affect the latched burst
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0 || regs_flat !== {4'hE, 4'hB, 4'h9, 4'h8, 4'hD, 4'hC})
      begin
         failures++;
         $display("FAIL burst_e0 got busy=%b rdy=%b regs=%h want 1 0 eb98dc",
                  busy, in_ready, regs_flat);
      end
      tick();  // E1
      checks++;
      if (regs_flat !== {4'hE, 4'hB, 4'h9, 4'h8, 4'h0, 4'hC}) begin
         failures++;
         $display("FAIL burst_e1 got=%h want=eb980c", regs_flat);
      end
      tick();  // E2
      checks++;
      if (regs_flat !== {4'hE, 4'hB, 4'h9, 4'h1, 4'h0, 4'hC}) begin
         failures++;
         $display("FAIL burst_e2 got=%h want=eb910c", regs_flat);
      end
      tick(); tick();  // E3, E4
      checks++;
      if (regs_flat !== {4'hE, 4'h3, 4'h2, 4'h1, 4'h0, 4'hC} || done !== 1'b1) begin
         failures++;
         $display("FAIL burst_final got=%h done=%b want=e3210c done=1", regs_flat, done);
      end
      tick();  // E5
      checks++;
      if (done !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL burst_idle got done=%b rdy=%b busy=%b want 0 1 0", done, in_ready, busy);
      end
   endtask

   task automatic test_wrap();
      int busy_cycles;
      in_data = {4'h0, 4'h0, 4'h0, 4'h9, 4'h7, 4'h2};
      in_count = 3'd3; in_base = 3'd4; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      busy_cycles = 0;
      for (int i = 0; i < 10 && busy; i++) begin
         busy_cycles++;
         tick();
      end
      checks++;
      if (busy_cycles != 4) begin
         failures++;
         $display("FAIL wrap_busy got=%0d want=4", busy_cycles);
      end
      checks++;
      if (regs_flat !== {4'h7, 4'h2, 4'h2, 4'h1, 4'h0, 4'h9}) begin
         failures++;
         $display("FAIL wrap_regs got=%h want=722109", regs_flat);
      end
      rd_addr = 3'd5;
      #1;
      checks++;
      if (rd_data !== 4'h7) begin
         failures++;
         $display("FAIL rd_addr5 got=%h want=7", rd_data);
      end
      rd_addr = 3'd7;
      #1;
      checks++;
      if (rd_data !== 4'h0) begin
         failures++;
         $display("FAIL rd_addr7 got=%h want=0", rd_data);
      end
   endtask

   task automatic test_illegal();
      for (int t = 0; t < 2; t++) begin
         in_data = {6{4'hF}};
         in_count = (t == 0) ? 3'd7 : 3'd1;
         in_base  = (t == 0) ? 3'd0 : 3'd6;
         in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         checks++;
         if (cmd_err !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL illegal%0d_pulse got err=%b rdy=%b busy=%b want 1 1 0",
                     t, cmd_err, in_ready, busy);
         end
         tick();
         checks++;
         if (cmd_err !== 1'b0 || regs_flat !== {4'h7, 4'h2, 4'h2, 4'h1, 4'h0, 4'h9}) begin
            failures++;
            $display("FAIL illegal%0d_after got err=%b regs=%h want 0 722109",
                     t, cmd_err, regs_flat);
         end
      end
      ext_write(3'd6, 4'h5);
      checks++;
      if (wr_drop !== 1'b1 || regs_flat !== {4'h7, 4'h2, 4'h2, 4'h1, 4'h0, 4'h9}) begin
         failures++;
         $display("FAIL ext_oob got drop=%b regs=%h want 1 722109", wr_drop, regs_flat);
      end
   endtask

   task automatic test_collision_and_zero();
      in_data = {4'h0, 4'h0, 4'h0, 4'h6, 4'h5, 4'h4};
      in_count = 3'd3; in_base = 3'd1; in_valid = 1'b1;
      wr_en = 1'b1; wr_addr = 3'd1; wr_data = 4'hF;
      tick();  // E0: external write lands, burst starts next edge
      in_valid = 1'b0;
      wr_addr = 3'd2; wr_data = 4'hA;  // arrives while busy
      checks++;
      if (regs_flat !== {4'h7, 4'h2, 4'h2, 4'h1, 4'hF, 4'h9} || wr_drop !== 1'b0) begin
         failures++;
         $display("FAIL collide_e0 got=%h drop=%b want=7221f9 drop=0", regs_flat, wr_drop);
      end
      tick();  // E1
      wr_en = 1'b0;
      checks++;
      if (wr_drop !== 1'b1 || regs_flat !== {4'h7, 4'h2, 4'h2, 4'h1, 4'h4, 4'h9}) begin
         failures++;
         $display("FAIL collide_e1 got drop=%b regs=%h want 1 722149", wr_drop, regs_flat);
      end
      tick(); tick();  // E2, E3
      checks++;
      if (regs_flat !== {4'h7, 4'h2, 4'h6, 4'h5, 4'h4, 4'h9} || wr_drop !== 1'b0 || done !== 1'b1)
      begin
         failures++;
         $display("FAIL collide_final got=%h drop=%b done=%b want=726549 0 1",
                  regs_flat, wr_drop, done);
      end
      tick();
      in_data = {6{4'h3}}; in_count = 3'd0; in_base = 3'd2; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if (done !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL zero_done got done=%b busy=%b rdy=%b want 1 1 0", done, busy, in_ready);
      end
      tick();
      checks++;
      if (done !== 1'b0 || in_ready !== 1'b1 || regs_flat !== {4'h7, 4'h2, 4'h6, 4'h5, 4'h4, 4'h9})
      begin
         failures++;
         $display("FAIL zero_after got done=%b rdy=%b regs=%h want 0 1 726549",
                  done, in_ready, regs_flat);
      end
   endtask

   task automatic test_reset_mid();
      in_data = {4'h0, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
      in_count = 3'd5; in_base = 3'd0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();  // two writes done
      checks++;
      if (regs_flat !== {4'h7, 4'h2, 4'h6, 4'h5, 4'h2, 4'h1}) begin
         failures++;
         $display("FAIL midrst_pre got=%h want=726521", regs_flat);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (regs_flat !== '0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL midrst_async got regs=%h busy=%b rdy=%b want 0 0 1",
                  regs_flat, busy, in_ready);
      end
      tick();
      rst_n = 1'b1;
      in_data = {4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h3};
      in_count = 3'd1; in_base = 3'd5; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || regs_flat !== '0) begin
         failures++;
         $display("FAIL midrst_accept got busy=%b regs=%h want 1 0", busy, regs_flat);
      end
      tick();
      checks++;
      if (regs_flat !== {4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0} || done !== 1'b1) begin
         failures++;
         $display("FAIL midrst_write got=%h done=%b want=300000 1", regs_flat, done);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_burst();
      test_wrap();
      test_illegal();
      test_collision_and_zero();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
